dram_port_arbiter: RTL and testbench
====================================

DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, which is the DRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 16, which is the DRAM word width.
REQ-003 SHALL have parameter BURST_LEN, default 4, which is the maximum beats per granted burst (power of two, at least 2).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have ports rd_req (input, 1), rd_addr (input, ADDR_W) and rd_gnt (output, 1): the input-FIFO fill requester.
REQ-007 SHALL have ports rd_valid (output, 1) and rd_data (output, DATA_W): the read return path to the FIFO.
REQ-008 SHALL have ports wr_req (input, 1), wr_addr (input, ADDR_W), wr_data (input, DATA_W) and wr_gnt (output, 1): the psum writeback requester.
REQ-009 SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W): the shared DRAM port.
REQ-010 SHALL have port mem_rdata, input, DATA_W: valid one cycle after a read beat.
REQ-011 SHALL have port mem_stall, input, 1: while high, no beat is issued.

Function
REQ-012 SHALL implement FSM states IDLE, RD_BURST and WR_BURST.
REQ-013 SHALL, in IDLE, issue no grant; the next state is RD_BURST or WR_BURST per arbitration (REQ-014, REQ-015), else IDLE. Arbitration latency is 1 cycle.
REQ-014 SHALL, when only one requester is high in IDLE, select that requester.
REQ-015 SHALL, when both requesters are high in IDLE, select the requester that is not last_owner (round-robin); last_owner is updated on entry to a burst state.
REQ-016 SHALL set rd_gnt = (state==RD_BURST) & rd_req & !mem_stall, and set wr_gnt likewise for WR_BURST; both SHALL never be high together.
REQ-017 SHALL drive mem_en = rd_gnt|wr_gnt and mem_we = wr_gnt; mem_addr SHALL be the granted requester's address, and mem_wdata = wr_data; all are 0 when not enabled.
REQ-018 SHALL keep a beat counter of width clog2(BURST_LEN), cleared on burst entry and incremented per grant.
REQ-019 SHALL return to IDLE on the grant with count == BURST_LEN-1 (burst complete).
REQ-020 SHALL, if the owner's req is low in a burst state, go to IDLE next cycle with no beat issued (early burst end).
REQ-021 SHALL hold state and counter during mem_stall; a stall does not end the burst.
REQ-022 SHALL register rd_valid high exactly one cycle after each rd_gnt, with rd_data = mem_rdata in that cycle; rd_data is 0 otherwise.
REQ-023 SHALL allow a requester whose burst just completed to rearbitrate in IDLE; under contention the other side wins.

Reset
REQ-024 SHALL, on rst low at a clock edge, set state=IDLE, counter=0, last_owner=WR (so the first contention goes to reads), and rd_valid=0.
REQ-025 SHALL hold all grants and mem_* outputs at 0 while rst is low.
REQ-026 SHALL abort any burst in progress at reset; a read beat granted in the cycle before reset SHALL NOT produce rd_valid.

Configuration
REQ-027 SHALL, with macro WR_PRIORITY_EN defined, select WR_BURST under IDLE contention regardless of last_owner, because psum writeback must not back up the psum buffer.
REQ-028 SHALL, without WR_PRIORITY_EN, use round-robin as in REQ-015.

Structure
REQ-029 SHALL place the FSM state enum, the owner encoding and the default ADDR_W, DATA_W and BURST_LEN constants in shared package cnn_mem_pkg.
REQ-030 SHALL implement the beat counter and completion detect as sub-module burst_counter (inputs: clear, inc; output: last).

Verification
REQ-031 SHALL cover a read-only case: rd_req held and rd_addr stepping 0..7 -> two 4-beat bursts with one idle cycle between, and rd_valid with data one cycle after each rd_gnt.
REQ-032 SHALL cover contention after reset: rd_req and wr_req rise together -> RD_BURST first for 4 beats, then WR_BURST for 4 beats; with WR_PRIORITY_EN, the order is reversed.
REQ-033 SHALL cover a stall: mem_stall high for 3 cycles at beat 2 of a write burst -> no grants for 3 cycles, the burst resumes, and exactly 4 mem_we beats occur.
REQ-034 SHALL cover early end: wr_req drops after 2 beats -> IDLE next cycle, and a pending rd_req is granted 1 cycle later.
REQ-035 SHALL cover reset mid-operation: rst low in the cycle after rd_gnt at beat 1 -> no rd_valid, and all outputs are 0 the next cycle.
REQ-036 SHALL cover grant exclusivity: a random req/stall stream over 10k cycles -> rd_gnt & wr_gnt is never 1, and mem_en == rd_gnt|wr_gnt every cycle.

Source files
------------

// File: rtl/cnn_mem_pkg.sv
// cnn_mem_pkg: shared DRAM-port types and default sizes.
// Holds the arbiter FSM state enum, the port-owner encoding and the
// default ADDR_W / DATA_W / BURST_LEN values used by dram_port_arbiter.
package cnn_mem_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int BURST_LEN_DEF = 4;
  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;
  typedef enum logic {OWN_RD, OWN_WR} owner_t;
endpackage

// File: rtl/burst_counter.sv
// burst_counter: beat counter for one granted burst with completion flag.
// Ports: clk, rst (sync active-low), clear (restart the burst count),
// inc (one beat issued), last (current beat is the final one, count == N-1).
module burst_counter #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic last
);
  localparam int W = $clog2(N);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst || clear) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  assign last = cnt == W'(N - 1);
endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one DRAM port between a FIFO-fill reader and a psum writer.
// Ports: clk, rst (sync active-low); rd_req/rd_addr/rd_gnt and rd_valid/rd_data
// (read requester and its one-cycle-late return); wr_req/wr_addr/wr_data/wr_gnt
// (writeback requester); mem_en/mem_we/mem_addr/mem_wdata/mem_rdata/mem_stall
// (shared DRAM port). Bursts are at most BURST_LEN beats; contention in IDLE is
// round-robin, or always won by writes when WR_PRIORITY_EN is defined.
module dram_port_arbiter
  import cnn_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stall
);
  state_t state, state_nx;
  owner_t last_owner, owner_nx;
  logic last, gnt, pick_wr, owner_req, rv_q;
`ifdef WR_PRIORITY_EN
  assign pick_wr = wr_req;
`else
  assign pick_wr = wr_req & (!rd_req | last_owner == OWN_RD);
`endif
  assign rd_gnt = rst & state == RD_BURST & rd_req & !mem_stall;
  assign wr_gnt = rst & state == WR_BURST & wr_req & !mem_stall;
  assign gnt = rd_gnt | wr_gnt;
  assign owner_req = state == RD_BURST ? rd_req : wr_req;
  assign mem_en = gnt;
  assign mem_we = wr_gnt;
  assign mem_addr = rd_gnt ? rd_addr : wr_gnt ? wr_addr : '0;
  assign mem_wdata = gnt ? wr_data : '0;
  // gating with rst drops the return of a beat granted just before reset
  assign rd_valid = rv_q & rst;
  assign rd_data = rd_valid ? mem_rdata : '0;
  always_comb begin
    state_nx = state;
    owner_nx = last_owner;
    if (state == IDLE) begin
      if (rd_req | wr_req) begin
        state_nx = pick_wr ? WR_BURST : RD_BURST;
        owner_nx = pick_wr ? OWN_WR : OWN_RD;
      end
    end else if (!owner_req || (gnt && last)) state_nx = IDLE;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      last_owner <= OWN_WR;
      rv_q <= 1'b0;
    end else begin
      state <= state_nx;
      last_owner <= owner_nx;
      rv_q <= rd_gnt;
    end
  burst_counter #(.N(BURST_LEN)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clear(state == IDLE),
    .inc(gnt),
    .last(last)
  );
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: random and directed checks against a transaction-level model.
module tb_dram_port_arbiter;
  localparam int AW = 10, DW = 16, BL = 4;
  logic clk = 0, rst = 0;
  logic rd_req = 0, wr_req = 0, mem_stall = 0;
  logic [AW-1:0] rd_addr = 0, wr_addr = 0;
  logic [DW-1:0] wr_data = 0, mem_rdata = 0;
  logic rd_gnt, rd_valid, wr_gnt, mem_en, mem_we;
  logic [DW-1:0] rd_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  int n_chk = 0, n_fail = 0;
  // model: who owns the port (0 none, 1 reader, 2 writer), beats done, whose turn on a tie
  int owner = 0, beats = 0;
  bit turn_wr = 0, prev_rg = 0;
  bit egr, ewg;
  int cnt_rg, cnt_wg, cnt_we;
  always #5 clk = ~clk;
  dram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic rq, input logic [AW-1:0] ra,
                      input logic wq, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic st);
    bit ev, pick_w;
    @(negedge clk);
    rst = r; rd_req = rq; rd_addr = ra; wr_req = wq; wr_addr = wa; wr_data = wd;
    mem_stall = st; mem_rdata = DW'($urandom);
    #1;
    egr = r && owner == 1 && rq && !st;
    ewg = r && owner == 2 && wq && !st;
    ev = r && prev_rg;
    check("rd_gnt", rd_gnt, egr);
    check("wr_gnt", wr_gnt, ewg);
    check("excl", rd_gnt & wr_gnt, 0);
    check("mem_en", mem_en, rd_gnt | wr_gnt);
    check("mem_we", mem_we, ewg);
    check("mem_addr", mem_addr, egr ? ra : ewg ? wa : 0);
    check("mem_wdata", mem_wdata, (egr || ewg) ? wd : 0);
    check("rd_valid", rd_valid, ev);
    check("rd_data", rd_data, ev ? mem_rdata : 0);
    cnt_rg += int'(egr); cnt_wg += int'(ewg); cnt_we += int'(mem_we);
    if (!r) begin
      owner = 0; beats = 0; turn_wr = 0; prev_rg = 0;
    end else begin
      prev_rg = egr;
      if (owner == 0) begin
        if (rq || wq) begin
`ifdef WR_PRIORITY_EN
          pick_w = wq;
`else
          pick_w = wq && (!rq || turn_wr);
`endif
          owner = pick_w ? 2 : 1;
          turn_wr = !pick_w;
          beats = 0;
        end
      end else if (!(owner == 1 ? rq : wq)) owner = 0;
      else if (!st) begin
        beats++;
        if (beats == BL) owner = 0;
      end
    end
  endtask
  task automatic do_reset();
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);
    cnt_rg = 0; cnt_wg = 0; cnt_we = 0;
  endtask
  initial begin
    logic [AW-1:0] a;
    int first_rd;
    do_reset();
    check("reset_en", mem_en, 0);
    check("reset_rv", rd_valid, 0);
    a = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, a, 0, 0, 0, 0);
      if (egr) a++;
    end
    step(1, 0, a, 0, 0, 0, 0);
    check("ro_beats", cnt_rg, 8);
    check("ro_addr", a, 8);
    do_reset();
    first_rd = -1;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, AW'(i), 1, AW'(100 + i), DW'(i), 0);
      if (first_rd < 0 && (rd_gnt || wr_gnt)) first_rd = int'(rd_gnt);
    end
`ifdef WR_PRIORITY_EN
    check("cont_first", first_rd, 0);
`else
    check("cont_first", first_rd, 1);
`endif
    check("cont_rd", cnt_rg, 4);
    check("cont_wr", cnt_wg, 4);
    do_reset();
    step(1, 0, 0, 1, 5, 16'h1111, 0);
    step(1, 0, 0, 1, 6, 16'h2222, 0);
    step(1, 0, 0, 1, 7, 16'h3333, 0);
    repeat (3) begin
      step(1, 0, 0, 1, 8, 16'h4444, 1);
      check("stall_gnt", mem_en, 0);
    end
    step(1, 0, 0, 1, 8, 16'h4444, 0);
    step(1, 0, 0, 1, 9, 16'h5555, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("stall_we", cnt_we, 4);
    do_reset();
    step(1, 0, 0, 1, 1, 1, 0);
    step(1, 1, 2, 1, 2, 2, 0);
    step(1, 1, 2, 1, 3, 3, 0);
    step(1, 1, 2, 0, 0, 0, 0);
    check("early_nobeat", mem_en, 0);
    step(1, 1, 2, 0, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0, 0);
    check("early_rd", rd_gnt, 1);
    check("early_wr", cnt_wg, 2);
    do_reset();
    step(1, 1, 3, 0, 0, 0, 0);
    step(1, 1, 3, 0, 0, 0, 0);
    step(1, 1, 4, 0, 0, 0, 0);
    check("mid_gnt", rd_gnt, 1);
    step(0, 1, 4, 0, 0, 0, 0);
    check("mid_rv", rd_valid, 0);
    check("mid_en", mem_en, 0);
    step(1, 1, 4, 0, 0, 0, 0);
    check("post_rv", rd_valid, 0);
    check("post_en", mem_en, 0);
    do_reset();
    for (int i = 0; i < 10000; i++)
      step($urandom_range(199) != 0, $urandom_range(9) < 7, AW'($urandom),
           $urandom_range(9) < 6, AW'($urandom), DW'($urandom), $urandom_range(4) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
